// File: rtl/hls_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hls_run_sequencer
// Purpose  : Runs an HLS kernel back-to-back a programmed number of times,
//            timing each run and checking its return value.
// Revision : 1.0  initial release
// ============================================================================
module hls_run_sequencer #(
  parameter int RET_W          = 32,
  parameter int CNT_W          = 32,
  parameter int RUN_W          = 16,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic [RUN_W-1:0]       cfg_runs,
  input  logic [RET_W-1:0]       cfg_expected,
  input  logic                   cfg_check,
  output logic                   kernel_start,
  input  logic                   kernel_done,
  input  logic [RET_W-1:0]       kernel_return,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout,
  output logic [RUN_W-1:0]       runs_done,
  output logic [RUN_W-1:0]       pass_count,
  output logic [RUN_W-1:0]       fail_count,
  output logic [CNT_W-1:0]       last_cycles,
  output logic [CNT_W-1:0]       min_cycles,
  output logic [CNT_W-1:0]       max_cycles,
  output logic [CNT_W+RUN_W-1:0] total_cycles
);

  localparam int               C_TOT_W   = CNT_W + RUN_W;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECORD = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [RUN_W-1:0]   runs_cfg_q, runs_cfg_d;
  logic [RET_W-1:0]   expected_q, expected_d;
  logic               check_q, check_d;
  logic [RET_W-1:0]   ret_q, ret_d;
  logic               kernel_start_q, kernel_start_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;
  logic               timeout_q, timeout_d;
  logic [RUN_W-1:0]   runs_done_q, runs_done_d;
  logic [RUN_W-1:0]   pass_q, pass_d;
  logic [RUN_W-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [C_TOT_W-1:0] total_q, total_d;
  logic [C_TOT_W:0]   w_total_sum;
  logic [RUN_W-1:0]   w_runs_next;

  always_comb begin
    state_d        = state_q;
    cyc_d          = cyc_q;
    runs_cfg_d     = runs_cfg_q;
    expected_d     = expected_q;
    check_d        = check_q;
    ret_d          = ret_q;
    timeout_d      = timeout_q;
    runs_done_d    = runs_done_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    last_d         = last_q;
    min_d          = min_q;
    max_d          = max_q;
    total_d        = total_q;
    w_total_sum    = {1'b0, total_q} + {{(RUN_W + 1){1'b0}}, last_q};
    w_runs_next    = runs_done_q + RUN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          runs_cfg_d  = cfg_runs;
          expected_d  = cfg_expected;
          check_d     = cfg_check;
          timeout_d   = 1'b0;
          runs_done_d = '0;
          pass_d      = '0;
          fail_d      = '0;
          last_d      = '0;
          min_d       = '1;
          max_d       = '0;
          total_d     = '0;
          state_d     = (cfg_runs != '0) ? ST_LAUNCH : ST_FINISH;
        end
      end
      ST_LAUNCH: begin
        cyc_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done in the same cycle as the watchdog limit still counts as a run.
        if (kernel_done) begin
          last_d  = cyc_q;
          ret_d   = kernel_return;
          state_d = ST_RECORD;
        end else if (cyc_q == C_TIMEOUT) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_RECORD: begin
        runs_done_d = w_runs_next;
        if (check_q) begin
          if (ret_q == expected_q) pass_d = pass_q + RUN_W'(1);
          else                     fail_d = fail_q + RUN_W'(1);
        end
        if (last_q < min_q) min_d = last_q;
        if (last_q > max_q) max_d = last_q;
        total_d = w_total_sum[C_TOT_W] ? '1 : w_total_sum[C_TOT_W-1:0];
        state_d = (w_runs_next == runs_cfg_q) ? ST_FINISH : ST_LAUNCH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they register cleanly.
    kernel_start_d = (state_d == ST_LAUNCH);
    busy_d         = (state_d != ST_IDLE);
    finished_d     = (state_d == ST_FINISH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cyc_q          <= '0;
      runs_cfg_q     <= '0;
      expected_q     <= '0;
      check_q        <= 1'b0;
      ret_q          <= '0;
      kernel_start_q <= 1'b0;
      busy_q         <= 1'b0;
      finished_q     <= 1'b0;
      timeout_q      <= 1'b0;
      runs_done_q    <= '0;
      pass_q         <= '0;
      fail_q         <= '0;
      last_q         <= '0;
      min_q          <= '1;
      max_q          <= '0;
      total_q        <= '0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      runs_cfg_q     <= runs_cfg_d;
      expected_q     <= expected_d;
      check_q        <= check_d;
      ret_q          <= ret_d;
      kernel_start_q <= kernel_start_d;
      busy_q         <= busy_d;
      finished_q     <= finished_d;
      timeout_q      <= timeout_d;
      runs_done_q    <= runs_done_d;
      pass_q         <= pass_d;
      fail_q         <= fail_d;
      last_q         <= last_d;
      min_q          <= min_d;
      max_q          <= max_d;
      total_q        <= total_d;
    end
  end

  assign kernel_start = kernel_start_q;
  assign busy         = busy_q;
  assign finished     = finished_q;
  assign timeout      = timeout_q;
  assign runs_done    = runs_done_q;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;
  assign last_cycles  = last_q;
  assign min_cycles   = min_q;
  assign max_cycles   = max_q;
  assign total_cycles = total_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_run_sequencer
// Purpose  : Directed, table-driven bench with a behavioural kernel model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hls_run_sequencer;

  localparam int TO = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [15:0] cfg_runs = '0;
  logic [31:0] cfg_expected = '0;
  logic        cfg_check = 1'b0;
  logic        kernel_start;
  logic        kernel_done;
  logic [31:0] kernel_return;
  logic        busy, finished, timeout;
  logic [15:0] runs_done, pass_count, fail_count;
  logic [31:0] last_cycles, min_cycles, max_cycles;
  logic [47:0] total_cycles;

  hls_run_sequencer #(
    .RET_W(32), .CNT_W(32), .RUN_W(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .cfg_runs(cfg_runs),
    .cfg_expected(cfg_expected), .cfg_check(cfg_check),
    .kernel_start(kernel_start), .kernel_done(kernel_done),
    .kernel_return(kernel_return), .busy(busy), .finished(finished),
    .timeout(timeout), .runs_done(runs_done), .pass_count(pass_count),
    .fail_count(fail_count), .last_cycles(last_cycles),
    .min_cycles(min_cycles), .max_cycles(max_cycles),
    .total_cycles(total_cycles)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // Kernel model: latency 0 in lat_a means the run never completes.
  int          lat_a[4];
  logic [31:0] ret_a[4];
  int          extra_hold = 0;
  int          epoch = 0;
  logic        spur_done = 1'b0;
  int          m_epoch = 0, m_cnt = 0, m_hold = 0, n_starts = 0;
  logic [31:0] m_ret = '0;
  logic        m_done;
  int          start_cyc[$];
  int          done_cyc[$];

  always @(negedge clock) begin
    m_done = 1'b0;
    if (m_epoch != epoch) begin
      m_epoch = epoch; m_cnt = 0; m_hold = 0; n_starts = 0;
      start_cyc.delete(); done_cyc.delete();
    end
    if (!reset) begin
      m_cnt = 0; m_hold = 0;
    end else begin
      if (m_hold > 0) begin m_done = 1'b1; m_hold--; end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1; done_cyc.push_back(cyc); m_hold = extra_hold;
        end
      end
      if (kernel_start) begin
        start_cyc.push_back(cyc);
        if (n_starts < 4) begin m_cnt = lat_a[n_starts]; m_ret = ret_a[n_starts]; end
        else m_cnt = 0;
        n_starts++;
      end
    end
    kernel_return = m_done ? m_ret : $urandom;
    kernel_done   = m_done | spur_done;
  end

  typedef struct {
    int          runs;
    logic [31:0] expv;
    bit          chk;
    int          lat0, lat1, lat2;
    logic [31:0] ret0, ret1, ret2;
    int          hold;
    bit          busy_go;
    int          e_runs, e_pass, e_fail;
    logic [31:0] e_last, e_min, e_max;
    logic [47:0] e_tot;
    bit          e_to;
    int          e_starts;
  } vec_t;

  vec_t vt[7];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, " kernel_start"}, kernel_start, 0);
    chk({p, " busy"}, busy, 0);
    chk({p, " finished"}, finished, 0);
    chk({p, " timeout"}, timeout, 0);
    chk({p, " runs_done"}, runs_done, 0);
    chk({p, " pass"}, pass_count, 0);
    chk({p, " fail"}, fail_count, 0);
    chk({p, " last"}, last_cycles, 0);
    chk({p, " min"}, min_cycles, 64'hFFFF_FFFF);
    chk({p, " max"}, max_cycles, 0);
    chk({p, " total"}, total_cycles, 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          la[4];
    logic [31:0] ra[4];
    int          es[$];
    int          g, t, fin_exp, fin_c;
    bit          fin_seen;
    la = '{v.lat0, v.lat1, v.lat2, 0};
    ra = '{v.ret0, v.ret1, v.ret2, 32'd0};
    @(negedge clock);
    lat_a = la; ret_a = ra; extra_hold = v.hold; epoch++;
    @(negedge clock);
    go = 1'b1; cfg_runs = 16'(v.runs); cfg_expected = v.expv; cfg_check = v.chk;
    g = cyc;
    // Expected start cycles and finished cycle from the latency table.
    t = g + 1; fin_exp = g + 1;
    for (int i = 0; i < v.runs && i < 4; i++) begin
      es.push_back(t);
      if (la[i] == 0) begin fin_exp = t + 1 + TO; break; end
      if (i == v.runs - 1) fin_exp = t + la[i] + 2;
      else                 t = t + la[i] + 2;
    end
    @(negedge clock);
    go = 1'b0; cfg_runs = 16'(v.runs + 1); cfg_expected = ~v.expv; cfg_check = ~v.chk;
    chk({nm, " busy_after_go"}, busy, 1);
    fin_seen = 1'b0; fin_c = 0;
    for (int k = 0; k < 300; k++) begin
      if (finished) begin fin_seen = 1'b1; fin_c = cyc; break; end
      go = v.busy_go && (k == 2);
      @(negedge clock);
    end
    go = 1'b0;
    chk({nm, " finished_seen"}, fin_seen, 1);
    chk({nm, " finished_cycle"}, fin_c, fin_exp);
    chk({nm, " runs_done"}, runs_done, v.e_runs);
    chk({nm, " pass"}, pass_count, v.e_pass);
    chk({nm, " fail"}, fail_count, v.e_fail);
    chk({nm, " last"}, last_cycles, v.e_last);
    chk({nm, " min"}, min_cycles, v.e_min);
    chk({nm, " max"}, max_cycles, v.e_max);
    chk({nm, " total"}, total_cycles, v.e_tot);
    chk({nm, " timeout"}, timeout, v.e_to);
    @(negedge clock);
    chk({nm, " finished_pulse"}, finished, 0);
    chk({nm, " busy_drop"}, busy, 0);
    chk({nm, " starts"}, n_starts, v.e_starts);
    for (int i = 0; i < start_cyc.size() && i < es.size(); i++)
      chk($sformatf("%s start%0d_cycle", nm, i), start_cyc[i], es[i]);
  endtask

  initial begin
    bit ok;
    #1 reset = 1'b0;
    #2 check_reset("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    //        runs exp    chk  lats     returns                     hold bgo  rd p f  last    min            max    total  to  starts
    vt[0] = '{1, 32'd42, 1'b1, 5, 0, 0, 32'd42, 32'd0, 32'd0, 0, 1'b0, 1, 1, 0, 32'd5, 32'd5,        32'd5, 48'd5,  1'b0, 1};
    vt[1] = '{3, 32'd9,  1'b1, 3, 7, 4, 32'd9,  32'd8, 32'd9, 2, 1'b1, 3, 2, 1, 32'd4, 32'd3,        32'd7, 48'd14, 1'b0, 3};
    vt[2] = '{2, 32'd0,  1'b0, 2, 6, 0, 32'd1,  32'd2, 32'd0, 0, 1'b0, 2, 0, 0, 32'd6, 32'd2,        32'd6, 48'd8,  1'b0, 2};
    vt[3] = '{1, 32'd7,  1'b1, 1, 0, 0, 32'd7,  32'd0, 32'd0, 0, 1'b0, 1, 1, 0, 32'd1, 32'd1,        32'd1, 48'd1,  1'b0, 1};
    vt[4] = '{0, 32'd0,  1'b1, 0, 0, 0, 32'd0,  32'd0, 32'd0, 0, 1'b0, 0, 0, 0, 32'd0, 32'hFFFFFFFF, 32'd0, 48'd0,  1'b0, 0};
    vt[5] = '{2, 32'd0,  1'b1, 0, 0, 0, 32'd0,  32'd0, 32'd0, 0, 1'b0, 0, 0, 0, 32'd0, 32'hFFFFFFFF, 32'd0, 48'd0,  1'b1, 1};
    vt[6] = '{1, 32'd5,  1'b1, 4, 0, 0, 32'd3,  32'd0, 32'd0, 0, 1'b1, 1, 0, 1, 32'd4, 32'd4,        32'd4, 48'd4,  1'b0, 1};

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Spurious done while idle must not disturb anything.
    @(negedge clock); spur_done = 1'b1;
    repeat (3) @(negedge clock);
    spur_done = 1'b0;
    @(negedge clock);
    chk("spur busy", busy, 0);
    chk("spur runs_done", runs_done, 1);
    chk("spur last", last_cycles, 4);
    chk("spur fail", fail_count, 1);

    // Asynchronous reset in the WAIT state of run 2 of 4.
    @(negedge clock);
    lat_a = '{5, 5, 5, 5}; ret_a = '{32'd1, 32'd1, 32'd1, 32'd1}; extra_hold = 0; epoch++;
    @(negedge clock);
    go = 1'b1; cfg_runs = 16'd4; cfg_expected = 32'd1; cfg_check = 1'b1;
    @(negedge clock);
    go = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock); #1;
      if (n_starts >= 2) begin ok = 1'b1; break; end
    end
    chk("mid reach_run2", ok, 1);
    @(negedge clock); @(negedge clock);
    chk("mid busy", busy, 1);
    chk("mid runs_done", runs_done, 1);
    chk("mid last", last_cycles, 5);
    #1 reset = 1'b0;
    #1 check_reset("mid_reset");
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    run_vec(vt[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
